// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, default frame parameters
// and the width helper also used by the baud generator and uart_tx.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_OVS     = 16;
  localparam int DEF_SB_TICK = 16;

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int uart_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int uart_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, assembled word,
// done strobe, framing error and busy flag out.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DBIT = DEF_DBIT
);

  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  // slave: the receiver itself
  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err,
    output busy
  );

  // master: tick generator / line driver and the word consumer
  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RST_VAL so the output never glitches out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, mid-bit data sampling, stop check;
// one-clk done pulse with dout/frame_err registered on the completing edge.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OVS     = DEF_OVS
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int SW = uart_clog2(uart_max(OVS, SB_TICK));
  localparam int NW = uart_clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  uart_state_t     state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_HALF) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_BIT) begin
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      STOP: begin
        // Counting from the last data sample lands mid-stop, leaving slack
        // for a start edge that follows the stop bit immediately.
        if (bus.s_tick) begin
          if (s_cnt_q == S_STOP) begin
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;
  assign bus.rx_done_tick = done_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
